leaf_out_arbiter: RTL
=====================

Name: leaf_out_arbiter

Overview:
- Sits between the user kernel's output streams and the 49-bit BFT egress of a leaf, in the clk_400 domain.
- Round-robin arbiter that shares the single BFT output link among NUM_OUT_PORTS user output streams.
- Gates each stream by a per-port credit counter (destination free space) and a per-port route table.
- Packs each granted 32-bit word into a BFT packet.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, sequence/address field width.
- NUM_OUT_PORTS, 2, number of user output streams (2..8).
- CREDIT_BITS, 8, credit counter width.
- FREESPACE_UPDATE_SIZE, 64, credit reset value per port; must be < 2^CREDIT_BITS.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i at slice i.
- vld_user2interface  in  NUM_OUT_PORTS  per-port word valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept; transfer occurs when vld&ack in the same cycle.
- dout_leaf_interface2bft  out  PACKET_BITS  packet. Fields: [48] valid, [47:43] leaf, [42:39] port, [38:32] seq, [31:0] payload.
- bft_ready  in  1  link accepts the current packet this cycle.
- cfg_we  in  1  route-table write strobe.
- cfg_port  in  NUM_PORT_BITS  output port index being configured.
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_dest_port  in  NUM_PORT_BITS  destination port.
- cfg_en  in  1  port enable.
- credit_vld  in  1  credit return strobe.
- credit_port  in  NUM_PORT_BITS  port receiving credit.
- credit_inc  in  CREDIT_BITS  credits returned.

Behaviour:
- Reset state (asynchronous):
  - dout = 0, ack = 0, output register EMPTY.
  - Route table: leaf = 0, port = 0, en = 0.
  - Credits = FREESPACE_UPDATE_SIZE; seq counters = 0; RR pointer = 0.
- Output register FSM, two states:
  - EMPTY: bit 48 = 0 and the whole bus is 0.
  - FULL: packet is driven and held stable until bft_ready = 1.
  - Transitions: EMPTY->FULL on grant. FULL->EMPTY on bft_ready with no grant. FULL->FULL on bft_ready with a new grant (back-to-back, 1 packet/cycle).
- Arbitration slot is open when state = EMPTY, or state = FULL and bft_ready = 1.
- Eligible port i: vld[i] & en[i] & credit[i] != 0.
- Round robin:
  - Search starts at RR pointer, upward, wrapping modulo NUM_OUT_PORTS.
  - First eligible port wins; pointer becomes winner+1 (mod NUM_OUT_PORTS).
  - No eligible port: pointer unchanged.
- Grant cycle t:
  - ack[winner] = 1, combinational, in cycle t; at most one ack bit high per cycle.
  - Packet = {1, leaf[w], port[w], seq[w], payload[w]}, registered at the t+1 edge (1-cycle latency).
  - seq[w] increments, wrapping 127->0.
  - credit[w] decrements.
- Credit return: credit[credit_port] += credit_inc.
  - Same-cycle grant and return on the same port: net = credit + inc - 1.
  - Saturates at 2^CREDIT_BITS-1.
  - credit_port >= NUM_OUT_PORTS is ignored.
- Configuration:
  - cfg_we updates the table entry for cfg_port next cycle; out-of-range cfg_port is ignored.
  - A packet already in the output register keeps its old header.
  - Clearing en for a port removes it from eligibility starting the next cycle.
- Credit = 0: port not acked and user holds vld; resumes on the cycle after credit is returned.
- bft_ready low while FULL: no acks to any port and no seq or credit change.
- Reset mid-packet: the in-flight packet is discarded and dout is forced to 0 immediately.

Optional Feature:
- Macro: LEAF_OUT_ARB_STATS_EN.
- Defined adds:
  - Input stat_sel (NUM_PORT_BITS).
  - Output stat_grants (32): wrapping grant counter of the selected port.
  - Output stat_stall (32): cycles the selected port had vld & en & credit = 0.
  - All counters reset to 0; stat_* output is registered (1-cycle read latency).
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Route setup: cfg port0 -> leaf 3/port 2, en. Push payload 0xDEADBEEF with bft_ready = 1. Required: ack0 high in cycle t; dout = 1_00011_0010_0000000_DEADBEEF at t+1; next packet seq = 1.
- Round robin: both ports enabled, both vld continuous, bft_ready = 1. Required: grants alternate 0,1,0,1 with one packet every cycle and never two acks in one cycle.
- Credit exhaustion: port0 only, 64 words sent. Required: 65th word not acked; credit_inc = 5 on port0 causes the next cycle to ack, and 5 more words flow.
- Backpressure: hold bft_ready = 0 for 10 cycles while FULL. Required: dout stable, zero acks; release -> packet consumed and the next grant loads the same cycle.
- Simultaneous events: grant and credit return (inc = 3) on port1 in the same cycle from credit 1. Required: credit = 3. Seq wrap: 128 words on one port, then the 129th carries seq 0.
- Async reset asserted while FULL. Required: dout = 0 without a clock edge, credits restored to 64, ports disabled.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that shares one BFT egress link among user output streams, with per-port credits and route table.
// Optional per-port statistics are compiled in with `define LEAF_OUT_ARB_STATS_EN.
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int CREDIT_BITS           = 8,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  bft_ready,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  cfg_en,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [CREDIT_BITS-1:0]                credit_inc
`ifdef LEAF_OUT_ARB_STATS_EN
  ,
  input  logic [NUM_PORT_BITS-1:0]              stat_sel,
  output logic [31:0]                           stat_grants,
  output logic [31:0]                           stat_stall
`endif
);

  localparam int PW = $clog2(NUM_OUT_PORTS);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]               r_state;
  logic [PACKET_BITS-1:0]   r_dout;
  logic [PW-1:0]            r_ptr;
  logic [NUM_LEAF_BITS-1:0] r_leaf   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] r_port   [NUM_OUT_PORTS];
  logic                     r_en     [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] r_seq    [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   r_credit [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] w_elig;
  logic                     w_slot, w_found, w_grant;
  logic [PW-1:0]            w_win;
  int                       w_idx;
  logic [PAYLOAD_BITS-1:0]  w_payload;
  logic [PACKET_BITS-1:0]   w_pkt;
  logic [NUM_OUT_PORTS-1:0] w_ack;
  logic [CREDIT_BITS:0]     w_sum;
  logic [CREDIT_BITS-1:0]   w_cred_nxt [NUM_OUT_PORTS];
  logic                     w_cfg_ok;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      w_elig[i] = vld_user2interface[i] & r_en[i] & (r_credit[i] != '0);
  end

  // Rotating priority search starting at the RR pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_OUT_PORTS;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

  assign w_slot    = (r_state == S_EMPTY) | bft_ready;
  assign w_grant   = w_slot & w_found;
  assign w_payload = din_leaf_user2interface[int'(w_win)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign w_pkt     = {1'b1, r_leaf[w_win], r_port[w_win], r_seq[w_win], w_payload};
  assign w_cfg_ok  = cfg_we & (int'(cfg_port) < NUM_OUT_PORTS);

  always_comb begin
    w_ack = '0;
    if (w_grant) w_ack[w_win] = 1'b1;
  end
  assign ack_interface2user      = w_ack;
  assign dout_leaf_interface2bft = r_dout;

  // Return and consume can hit the same port; a grant implies credit >= 1 so no underflow.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_sum = {1'b0, r_credit[i]};
      if (credit_vld && int'(credit_port) == i) w_sum = w_sum + {1'b0, credit_inc};
      if (w_grant && int'(w_win) == i)          w_sum = w_sum - (CREDIT_BITS+1)'(1);
      w_cred_nxt[i] = w_sum[CREDIT_BITS] ? '1 : w_sum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
      r_dout  <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_leaf[i]   <= '0;
        r_port[i]   <= '0;
        r_en[i]     <= 1'b0;
        r_seq[i]    <= '0;
        r_credit[i] <= CREDIT_BITS'(FREESPACE_UPDATE_SIZE);
      end
    end else begin
      if (w_grant) begin
        r_state      <= S_FULL;
        r_dout       <= w_pkt;
        r_seq[w_win] <= r_seq[w_win] + 1'b1;
        r_ptr        <= PW'((int'(w_win) + 1) % NUM_OUT_PORTS);
      end else if (bft_ready) begin
        r_state <= S_EMPTY;
        r_dout  <= '0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) r_credit[i] <= w_cred_nxt[i];
      if (w_cfg_ok) begin
        r_leaf[cfg_port[PW-1:0]] <= cfg_dest_leaf;
        r_port[cfg_port[PW-1:0]] <= cfg_dest_port;
        r_en[cfg_port[PW-1:0]]   <= cfg_en;
      end
    end
  end

`ifdef LEAF_OUT_ARB_STATS_EN
  logic [31:0] r_gcnt [NUM_OUT_PORTS];
  logic [31:0] r_scnt [NUM_OUT_PORTS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grants <= '0;
      stat_stall  <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_gcnt[i] <= '0;
        r_scnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (w_ack[i]) r_gcnt[i] <= r_gcnt[i] + 32'd1;
        if (vld_user2interface[i] && r_en[i] && r_credit[i] == '0) r_scnt[i] <= r_scnt[i] + 32'd1;
      end
      if (int'(stat_sel) < NUM_OUT_PORTS) begin
        stat_grants <= r_gcnt[stat_sel[PW-1:0]];
        stat_stall  <= r_scnt[stat_sel[PW-1:0]];
      end else begin
        stat_grants <= '0;
        stat_stall  <= '0;
      end
    end
  end
`endif

endmodule
